yarp_lsu: RTL

YARP_LSU -- requirements
Module: yarp_lsu

---
 rtl/yarp_lsu.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/yarp_lsu.sv
// Load/store unit: turns one core data access into a single-beat bus transaction
// with byte-lane steering, load extension, alignment rejection and a wait timeout.
module yarp_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lsu_req_i,
  input  logic        lsu_wr_i,
  input  logic [1:0]  lsu_byte_i,
  input  logic        lsu_zero_extnd_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misaligned_o,
  output logic        lsu_timeout_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        zext_q;
  logic        legal;
  logic        tmo_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] shifted;
  logic [31:0] load_fmt;

  always_comb begin
    legal     = 1'b0;
    be_nxt    = 4'b1111;
    wdata_nxt = lsu_wdata_i;
    case (lsu_byte_i)
      2'b00: begin
        legal     = 1'b1;
        be_nxt    = 4'b0001 << lsu_addr_i[1:0];
        wdata_nxt = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        legal     = ~lsu_addr_i[0];
        be_nxt    = 4'b0011 << lsu_addr_i[1:0];
        wdata_nxt = {2{lsu_wdata_i[15:0]}};
      end
      2'b11: legal = (lsu_addr_i[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Timeout fires on the cycle the count would reach the limit; progress in
  // that same cycle takes priority because grant/rvalid are tested first.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && ((cnt + 32'd1) == TIMEOUT_CYCLES);

  always_comb begin
    shifted = mem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_fmt = zext_q ? {24'h0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_fmt = zext_q ? {16'h0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  always_comb begin
    state_nxt        = state;
    lsu_stall_o      = 1'b0;
    lsu_misaligned_o = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_req_i && legal) begin
          state_nxt   = REQ;
          lsu_stall_o = 1'b1;
        end else if (lsu_req_i) begin
          lsu_misaligned_o = 1'b1;
        end
      end
      REQ: begin
        lsu_stall_o = 1'b1;
        if (mem_gnt_i)    state_nxt = mem_we_o ? DONE : WAIT;
        else if (tmo_hit) state_nxt = DONE;
      end
      WAIT: begin
        lsu_stall_o = 1'b1;
        if (mem_rvalid_i || tmo_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!reset_n) begin
      lsu_stall_o      = 1'b0;
      lsu_misaligned_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_be_o      <= '0;
      mem_wdata_o   <= '0;
      lsu_rdata_o   <= '0;
      lsu_timeout_o <= 1'b0;
      off_q         <= '0;
      size_q        <= '0;
      zext_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      lsu_timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_req_i && legal) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= lsu_wr_i;
            mem_addr_o  <= {lsu_addr_i[31:2], 2'b00};
            mem_be_o    <= be_nxt;
            mem_wdata_o <= wdata_nxt;
            off_q       <= lsu_addr_i[1:0];
            size_q      <= lsu_byte_i;
            zext_q      <= lsu_zero_extnd_i;
            cnt         <= '0;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            cnt       <= '0;
            if (mem_we_o) lsu_rdata_o <= '0;
          end else if (tmo_hit) begin
            mem_req_o     <= 1'b0;
            lsu_timeout_o <= 1'b1;
            lsu_rdata_o   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            lsu_rdata_o <= load_fmt;
          end else if (tmo_hit) begin
            lsu_timeout_o <= 1'b1;
            lsu_rdata_o   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DONE:    lsu_rdata_o <= '0;
        default: ;
      endcase
    end
  end

endmodule
